softmax_normalizer: RTL and testbench
=====================================

Name: softmax_normalizer

Overview:
- Consumer end of the adder-tree output interface in the Q8.8 softmax path.
- Takes the reduced sum plus the propagated element vector from the tree.
- Divides every element by the sum using a sequential restoring divider, one element at a time.
- Emits the normalized Q8.8 vector with a one-cycle valid pulse.

Parameters:
- N, 8, number of 16-bit Q8.8 elements in the vector (N >= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; when 0, all state, counters and outputs hold.
- valid_in  input  1  sum_in/in_flat valid (driven from tree valid_out).
- sum_in  input  16  unsigned Q8.8 divisor (tree out).
- in_flat  input  N*16  unsigned Q8.8 elements (tree out_prop); element i at bits [i*16+15:i*16].
- out_flat  output  N*16  normalized Q8.8 results, same packing as in_flat.
- valid_out  output  1  one-cycle pulse: out_flat holds a new complete result.
- busy  output  1  high while a vector is being divided.

Behaviour:
- Reset: out_flat=0, valid_out=0, busy=0, state=IDLE, element index=0, bit counter=0, internal registers=0. Reset overrides en. Reset mid-operation aborts the current vector; no valid_out is produced.
- en=0: freezes every register, including valid_out (a pulse is stretched while en=0). Division resumes exactly where it stopped.
- States: IDLE, DIV.
- IDLE, with en=1 and valid_in=1 on an edge:
  - Latch sum_in and in_flat.
  - Load element 0 dividend = elem<<8 (24 bits); clear remainder and quotient.
  - Go to DIV; busy=1.
- DIV: one restoring-division step per enabled cycle, with 24 steps per element.
  - Remainder is 17 bits.
  - Each step: rem = {rem[15:0], next dividend MSB}. If rem >= sum, subtract sum and shift in quotient bit 1; otherwise shift in 0.
- Element result after the 24th step:
  - If sum==0, result = 16'hFFFF (divide-by-zero).
  - Else if quotient[23:16] != 0, result = 16'hFFFF (saturation).
  - Else result = quotient[15:0], truncated toward zero.
  - Write the result into out_flat slot i at the same edge.
- Element sequencing: if i < N-1, load element i+1 and continue. If i == N-1, go to IDLE, set busy=0 and valid_out=1 at that same edge.
- Latency with en held 1: accept edge at cycle k, valid_out high in the cycle after edge k+24*N. Example: N=8 gives 192 cycles.
- Intermediate values:
  - out_flat slots update progressively during DIV.
  - Consumers must sample out_flat only while valid_out=1.
  - out_flat holds after completion until overwritten by the next vector.
- valid_out clears on the next enabled edge.
- valid_in while busy is ignored; there is no queueing and the upstream must not rely on capture.
- A new valid_in is accepted in the same cycle valid_out is high, since the state is IDLE. Back-to-back throughput is one vector per 24*N+1 cycles.
- Arithmetic is unsigned throughout; input values with bit 15 set are treated as large positive magnitudes.

Test Plan:
- Basic normalization, N=8, en=1:
  - Stimulus: sum_in=16'h2400, elements 16'h0100..16'h0800, one-cycle valid_in.
  - Required: after 192 cycles, valid_out pulses once.
  - Required out_flat slots 0..7 = 0007, 000E, 0015, 001C, 0023, 002A, 0031, 0038.
- Identity and saturation:
  - Stimulus: sum_in=16'h0100, elements 16'h0100 (slot 0) and 16'h0200 (slot 1).
  - Required: slot 0 = 16'h0100, slot 1 = 16'h0200.
  - Stimulus: sum_in=16'h0001, element 16'h0200.
  - Required: that slot = 16'hFFFF.
- Divide-by-zero:
  - Stimulus: sum_in=0, any elements.
  - Required: every slot = 16'hFFFF; valid_out still pulses at the normal latency.
- Stall:
  - Stimulus: drop en for 10 cycles mid-DIV.
  - Required: valid_out appears exactly 10 cycles later than the case-1 timing with identical out_flat; a valid_out pulse coinciding with en=0 stays high until en returns.
- Busy / back-to-back:
  - Stimulus: assert valid_in with different data during DIV.
  - Required: results reflect only the first vector.
  - Stimulus: assert valid_in in the valid_out cycle.
  - Required: second vector accepted; busy=1 on the next cycle.
- Reset mid-operation:
  - Stimulus: rst=1 for 1 cycle at step 50 of vector 1.
  - Required: out_flat=0, busy=0, valid_out=0, with no pulse from the aborted vector.
  - Stimulus: a following vector.
  - Required: it completes with normal latency and correct values.

Source files
------------

// File: rtl/softmax_normalizer.sv
// softmax_normalizer: divides each Q8.8 element of a vector by the Q8.8 sum
// using a 24-step restoring divider, one element at a time.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            global enable; all state holds while low
//   valid_in      sum_in/in_flat valid (accepted only when idle)
//   sum_in        unsigned Q8.8 divisor
//   in_flat       N unsigned Q8.8 elements, element i at [i*16 +: 16]
//   out_flat      normalized Q8.8 results, same packing
//   valid_out     one-cycle pulse when out_flat holds a complete result
//   busy          high while a vector is being divided
module softmax_normalizer #(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            valid_in,
    input  logic [15:0]     sum_in,
    input  logic [N*16-1:0] in_flat,
    output logic [N*16-1:0] out_flat,
    output logic            valid_out,
    output logic            busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        DIV
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [4:0]      bit_q, bit_d;
    logic [15:0]     sum_q, sum_d;
    logic [N*16-1:0] elem_q, elem_d;
    logic [23:0]     dvd_q, dvd_d;
    logic [16:0]     rem_q, rem_d;
    logic [23:0]     quo_q, quo_d;
    logic [N*16-1:0] out_q, out_d;
    logic            valid_q, valid_d;

    logic [16:0]     rem_sh;
    logic            ge;
    logic [16:0]     rem_nx;
    logic [23:0]     quo_nx;
    logic [15:0]     res;
    logic [N*16-1:0] elem_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            sum_q   <= '0;
            elem_q  <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            sum_q   <= sum_d;
            elem_q  <= elem_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    // One restoring-division step on the current element.
    always_comb begin
        rem_sh = {rem_q[15:0], dvd_q[23]};
        ge     = (rem_sh >= {1'b0, sum_q});
        rem_nx = ge ? (rem_sh - {1'b0, sum_q}) : rem_sh;
        quo_nx = {quo_q[22:0], ge};
        if (sum_q == 16'h0000) begin
            res = 16'hFFFF;
        end else if (quo_nx[23:16] != 8'h00) begin
            res = 16'hFFFF;
        end else begin
            res = quo_nx[15:0];
        end
        // Elements are consumed from the bottom; the next one sits at [31:16].
        elem_sh = elem_q >> 16;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        sum_d   = sum_q;
        elem_d  = elem_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        out_d   = out_q;
        valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    sum_d   = sum_in;
                    elem_d  = in_flat;
                    dvd_d   = {in_flat[15:0], 8'h00};
                    rem_d   = '0;
                    quo_d   = '0;
                    idx_d   = '0;
                    bit_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                dvd_d = {dvd_q[22:0], 1'b0};
                rem_d = rem_nx;
                quo_d = quo_nx;
                bit_d = bit_q + 5'd1;
                if (bit_q == 5'd23) begin
                    for (int i = 0; i < N; i++) begin
                        if (idx_q == IW'(i)) begin
                            out_d[i*16 +: 16] = res;
                        end
                    end
                    bit_d = '0;
                    if (idx_q == IW'(N - 1)) begin
                        state_d = IDLE;
                        valid_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        elem_d = elem_sh;
                        dvd_d  = {elem_sh[15:0], 8'h00};
                        rem_d  = '0;
                        quo_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_flat  = out_q;
    assign valid_out = valid_q;
    assign busy      = (state_q == DIV);

endmodule

// File: tb/tb_softmax_normalizer.sv
// tb_softmax_normalizer: scoreboard bench for softmax_normalizer.
// Expected vectors and due cycles are queued at drive time.
module tb_softmax_normalizer;

    localparam int N   = 8;
    localparam int LAT = 24 * N;

    typedef struct {
        logic [N*16-1:0] data;
        int              due;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b1;
    logic            valid_in = 1'b0;
    logic [15:0]     sum_in = '0;
    logic [N*16-1:0] in_flat = '0;
    logic [N*16-1:0] out_flat;
    logic            valid_out;
    logic            busy;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic vo_prev = 1'b0;
    exp_t sb[$];

    softmax_normalizer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .valid_in  (valid_in),
        .sum_in    (sum_in),
        .in_flat   (in_flat),
        .out_flat  (out_flat),
        .valid_out (valid_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [N*16-1:0] model(input logic [15:0] s,
                                              input logic [N*16-1:0] v);
        logic [N*16-1:0] r;
        logic [31:0]     q;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (s == 16'h0000) begin
                r[i*16 +: 16] = 16'hFFFF;
            end else begin
                q = {8'h00, v[i*16 +: 16], 8'h00} / {16'h0000, s};
                r[i*16 +: 16] = (q > 32'h0000_FFFF) ? 16'hFFFF : q[15:0];
            end
        end
        return r;
    endfunction

    // Monitor: compare each new valid_out pulse against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (valid_out && !vo_prev && !rst) begin
            if (sb.size() == 0) begin
                check("unexpected_vo", 1, 0);
            end else begin
                e = sb.pop_front();
                check("data", out_flat, e.data);
                check("latency", cyc, e.due);
            end
        end
        vo_prev <= valid_out;
    end

    // Called just after a negedge; returns at the next negedge.
    task automatic send(input logic [15:0] s, input logic [N*16-1:0] v,
                        input int extra);
        exp_t e;
        sum_in   = s;
        in_flat  = v;
        valid_in = 1'b1;
        e.data   = model(s, v);
        e.due    = cyc + 1 + LAT + extra;
        sb.push_back(e);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", 0, 1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_vo(input int budget, output logic seen);
        int n = 0;
        while (!valid_out && n < budget) begin
            @(negedge clk);
            n++;
        end
        seen = valid_out;
        if (!seen) check("vo_timeout", 0, 1);
    endtask

    logic [N*16-1:0] v1;
    logic [N*16-1:0] vr;
    logic            seen;

    initial begin
        for (int i = 0; i < N; i++) v1[i*16 +: 16] = 16'((i + 1) * 256);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out", out_flat, 0);
        check("rst_vo", valid_out, 0);
        check("rst_busy", busy, 0);

        // Basic normalization
        send(16'h2400, v1, 0);
        check("busy_after_accept", busy, 1);
        wait_done(LAT + 20);

        // Identity, saturation, divide-by-zero
        vr = '0;
        vr[15:0]  = 16'h0100;
        vr[31:16] = 16'h0200;
        vr[47:32] = 16'h8000;
        send(16'h0100, vr, 0);
        wait_done(LAT + 20);
        vr = '0;
        vr[15:0] = 16'h0200;
        send(16'h0001, vr, 0);
        wait_done(LAT + 20);
        send(16'h0000, v1, 0);
        wait_done(LAT + 20);

        // Random vectors
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) vr[i*16 +: 16] = 16'($urandom);
            send(16'($urandom_range(1, 65535)), vr, 0);
            wait_done(LAT + 20);
        end

        // Stall mid-division
        send(16'h2400, v1, 10);
        repeat (50) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        wait_done(LAT + 40);

        // valid_out stretched while en is low
        send(16'h1234, v1, 0);
        wait_vo(LAT + 20, seen);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("vo_stretch", valid_out, 1);
        end
        en = 1'b1;
        @(negedge clk);
        check("vo_clear", valid_out, 0);
        wait_done(20);

        // valid_in while busy is ignored
        send(16'h0300, v1, 0);
        repeat (20) @(negedge clk);
        sum_in   = 16'h0001;
        in_flat  = ~v1;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check("busy_ignore", busy, 1);
        wait_done(LAT + 20);
        repeat (LAT + 10) @(negedge clk);

        // Back-to-back: accept in the valid_out cycle
        send(16'h0500, v1, 0);
        wait_vo(LAT + 20, seen);
        send(16'h0700, ~v1, 0);
        check("b2b_busy", busy, 1);
        wait_done(LAT + 20);

        // Reset mid-operation
        send(16'h2400, v1, 0);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out", out_flat, 0);
        check("midrst_busy", busy, 0);
        check("midrst_vo", valid_out, 0);
        repeat (LAT + 20) @(negedge clk);
        send(16'h0A00, v1, 0);
        wait_done(LAT + 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
